// File: rtl/dmem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dmem_port_arbiter
// Description : Shares one single-port data memory between the processor
//               load/store path (port C) and a debug/IO loader (port D).
//               Writes complete in the grant cycle; reads take two cycles
//               (strobe, then data). Round-robin on ties, port C first after
//               reset. Stalls the processor while its access is pending and
//               counts stall cycles in a saturating counter.
// Ports       : clk, reset                 - clock, synchronous active-high reset
//               c_req/c_we/c_addr/c_wdata  - processor request
//               c_rdata/c_done/c_stall     - processor response / freeze
//               d_req/d_we/d_addr/d_wdata  - debug request
//               d_rdata/d_done             - debug response
//               mem_addr/mem_wdata/mem_we/mem_re/mem_rdata - memory side
//               stall_cnt                  - saturating stall-cycle count
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_port_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  c_req,
    input  logic                  c_we,
    input  logic [ADDR_WIDTH-1:0] c_addr,
    input  logic [DATA_WIDTH-1:0] c_wdata,
    output logic [DATA_WIDTH-1:0] c_rdata,
    output logic                  c_done,
    output logic                  c_stall,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    output logic [DATA_WIDTH-1:0] d_rdata,
    output logic                  d_done,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_we,
    output logic                  mem_re,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic [CNT_WIDTH-1:0]  stall_cnt
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_C_RD = 2'd1,
        S_D_RD = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_nextState;
    logic                  r_lastGrantD;   // 1: port D won the most recent grant
    logic [ADDR_WIDTH-1:0] r_addr;         // read address held through *_RD
    logic [DATA_WIDTH-1:0] r_cRdata;
    logic [DATA_WIDTH-1:0] r_dRdata;
    logic [CNT_WIDTH-1:0]  r_stallCnt;
    logic                  w_grantC;
    logic                  w_grantD;

    // Grants and done pulses are suppressed while reset is asserted so that a
    // read interrupted by reset produces no completion and no memory access
    // starts in the reset cycle.
    always_comb begin
        w_nextState = r_state;
        w_grantC    = 1'b0;
        w_grantD    = 1'b0;
        mem_we      = 1'b0;
        mem_re      = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        c_done      = 1'b0;
        d_done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!reset) begin
                    // On a tie, C wins unless C won last time.
                    if (c_req && (!d_req || r_lastGrantD)) begin
                        w_grantC = 1'b1;
                    end else if (d_req) begin
                        w_grantD = 1'b1;
                    end
                end
                if (w_grantC) begin
                    mem_addr = c_addr;
                    if (c_we) begin
                        mem_we    = 1'b1;
                        mem_wdata = c_wdata;
                        c_done    = 1'b1;
                    end else begin
                        mem_re      = 1'b1;
                        w_nextState = S_C_RD;
                    end
                end else if (w_grantD) begin
                    mem_addr = d_addr;
                    if (d_we) begin
                        mem_we    = 1'b1;
                        mem_wdata = d_wdata;
                        d_done    = 1'b1;
                    end else begin
                        mem_re      = 1'b1;
                        w_nextState = S_D_RD;
                    end
                end
            end
            S_C_RD: begin
                mem_addr    = r_addr;
                c_done      = ~reset;
                w_nextState = S_IDLE;
            end
            S_D_RD: begin
                mem_addr    = r_addr;
                d_done      = ~reset;
                w_nextState = S_IDLE;
            end
            default: begin
                w_nextState = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_lastGrantD <= 1'b1;
            r_addr       <= '0;
            r_cRdata     <= '0;
            r_dRdata     <= '0;
            r_stallCnt   <= '0;
        end else begin
            r_state <= w_nextState;
            if (w_grantC) begin
                r_lastGrantD <= 1'b0;
            end else if (w_grantD) begin
                r_lastGrantD <= 1'b1;
            end
            if (mem_re) begin
                r_addr <= mem_addr;
            end
            if (r_state == S_C_RD) begin
                r_cRdata <= mem_rdata;
            end
            if (r_state == S_D_RD) begin
                r_dRdata <= mem_rdata;
            end
            if (c_stall && (r_stallCnt != {CNT_WIDTH{1'b1}})) begin
                r_stallCnt <= r_stallCnt + CNT_WIDTH'(1);
            end
        end
    end

    // Read data is presented straight from memory in the done cycle and held
    // in the capture register afterwards.
    assign c_rdata   = ((r_state == S_C_RD) && !reset) ? mem_rdata : r_cRdata;
    assign d_rdata   = ((r_state == S_D_RD) && !reset) ? mem_rdata : r_dRdata;
    assign c_stall   = c_req & ~c_done;
    assign stall_cnt = r_stallCnt;

endmodule
`default_nettype wire

// File: tb/tb_dmem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_port_arbiter
// Description : Directed self-checking bench for dmem_port_arbiter. A small
//               synchronous memory model sits on the memory port. A second
//               instance with a 4-bit stall counter shares all inputs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_port_arbiter;

    logic        clk;
    logic        reset;
    logic        cReq, cWe, dReq, dWe;
    logic [31:0] cAddr, cWdata, dAddr, dWdata;
    logic [31:0] cRdata, dRdata, memAddr, memWdata, memRdata;
    logic        cDone, cStall, dDone, memWe, memRe;
    logic [15:0] stallCnt;
    logic [31:0] cRdata4, dRdata4, memAddr4, memWdata4;
    logic        cDone4, cStall4, dDone4, memWe4, memRe4;
    logic [3:0]  stallCnt4;
    logic [31:0] memArr [0:63];

    int nVec = 0;
    int nErr = 0;

    localparam logic [31:0] c_DATA_A = 32'hA5A5_0020;
    localparam logic [31:0] c_DATA_B = 32'h5A5A_0024;

    dmem_port_arbiter dut (
        .clk(clk), .reset(reset),
        .c_req(cReq), .c_we(cWe), .c_addr(cAddr), .c_wdata(cWdata),
        .c_rdata(cRdata), .c_done(cDone), .c_stall(cStall),
        .d_req(dReq), .d_we(dWe), .d_addr(dAddr), .d_wdata(dWdata),
        .d_rdata(dRdata), .d_done(dDone),
        .mem_addr(memAddr), .mem_wdata(memWdata), .mem_we(memWe), .mem_re(memRe),
        .mem_rdata(memRdata), .stall_cnt(stallCnt)
    );

    dmem_port_arbiter #(.CNT_WIDTH(4)) dut4 (
        .clk(clk), .reset(reset),
        .c_req(cReq), .c_we(cWe), .c_addr(cAddr), .c_wdata(cWdata),
        .c_rdata(cRdata4), .c_done(cDone4), .c_stall(cStall4),
        .d_req(dReq), .d_we(dWe), .d_addr(dAddr), .d_wdata(dWdata),
        .d_rdata(dRdata4), .d_done(dDone4),
        .mem_addr(memAddr4), .mem_wdata(memWdata4), .mem_we(memWe4), .mem_re(memRe4),
        .mem_rdata(memRdata), .stall_cnt(stallCnt4)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Synchronous memory: write on the strobe edge, read data valid next cycle.
    always @(posedge clk) begin
        if (memWe) memArr[memAddr[7:2]] <= memWdata;
        if (memRe) memRdata <= memArr[memAddr[7:2]];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clearInputs();
        cReq = 0; cWe = 0; cAddr = '0; cWdata = '0;
        dReq = 0; dWe = 0; dAddr = '0; dWdata = '0;
    endtask

    task automatic test_reset();
        reset = 1;
        clearInputs();
        repeat (2) tick();
        @(negedge clk);
        nVec++;
        if ({cDone, dDone, memWe, memRe} !== 4'b0000) begin
            nErr++; $display("FAIL reset_strobes: got %b, want 0000", {cDone, dDone, memWe, memRe});
        end
        nVec++;
        if ({memAddr, memWdata} !== 64'd0) begin
            nErr++; $display("FAIL reset_membus: got %h/%h, want 0/0", memAddr, memWdata);
        end
        nVec++;
        if ({cRdata, dRdata} !== 64'd0) begin
            nErr++; $display("FAIL reset_rdata: got %h/%h, want 0/0", cRdata, dRdata);
        end
        nVec++;
        if (stallCnt !== 16'd0 || stallCnt4 !== 4'd0) begin
            nErr++; $display("FAIL reset_cnt: got %0d/%0d, want 0/0", stallCnt, stallCnt4);
        end
        tick();
        reset = 0;
    endtask

    task automatic test_write_read();
        cReq = 1; cWe = 1; cAddr = 32'h10; cWdata = 32'hDEADBEEF;
        @(negedge clk);
        nVec++;
        if ({memWe, memRe, cDone, cStall} !== 4'b1010) begin
            nErr++; $display("FAIL cwr_strobes: got %b, want 1010", {memWe, memRe, cDone, cStall});
        end
        nVec++;
        if (memAddr !== 32'h10 || memWdata !== 32'hDEADBEEF) begin
            nErr++; $display("FAIL cwr_bus: got %h/%h, want 00000010/deadbeef", memAddr, memWdata);
        end
        tick();
        cWe = 0;
        @(negedge clk);
        nVec++;
        if ({memRe, cDone, cStall} !== 3'b101) begin
            nErr++; $display("FAIL crd_issue: got %b, want 101", {memRe, cDone, cStall});
        end
        tick();
        @(negedge clk);
        nVec++;
        if (cDone !== 1'b1 || cStall !== 1'b0 || cRdata !== 32'hDEADBEEF) begin
            nErr++; $display("FAIL crd_done: got done=%b stall=%b data=%h, want 1 0 deadbeef", cDone, cStall, cRdata);
        end
        tick();
        cReq = 0;
        @(negedge clk);
        nVec++;
        if (stallCnt !== 16'd1) begin
            nErr++; $display("FAIL crd_stallcnt: got %0d, want 1", stallCnt);
        end
        tick();
    endtask

    task automatic test_tie();
        dReq = 1; dWe = 1; dAddr = 32'h20; dWdata = c_DATA_A;
        @(negedge clk);
        nVec++;
        if (dDone !== 1'b1) begin
            nErr++; $display("FAIL dwr_done0: got %b, want 1", dDone);
        end
        tick();
        dAddr = 32'h24; dWdata = c_DATA_B;
        @(negedge clk);
        nVec++;
        if (dDone !== 1'b1) begin
            nErr++; $display("FAIL dwr_done1: got %b, want 1", dDone);
        end
        tick();
        dReq = 0;
        reset = 1;
        tick();
        reset = 0;
        cReq = 1; cWe = 0; cAddr = 32'h20;
        dReq = 1; dWe = 0; dAddr = 32'h24;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            nVec++;
            if (memRe !== 1'b1 || cStall !== 1'b1 || memAddr !== ((i % 2 == 0) ? 32'h20 : 32'h24)) begin
                nErr++; $display("FAIL tie%0d_grant: got re=%b stall=%b addr=%h, want 1 1 %h",
                                 i, memRe, cStall, memAddr, (i % 2 == 0) ? 32'h20 : 32'h24);
            end
            tick();
            @(negedge clk);
            nVec++;
            if (i % 2 == 0) begin
                if (cDone !== 1'b1 || dDone !== 1'b0 || cRdata !== c_DATA_A) begin
                    nErr++; $display("FAIL tie%0d_cdone: got c=%b d=%b data=%h, want 1 0 %h", i, cDone, dDone, cRdata, c_DATA_A);
                end
            end else begin
                if (dDone !== 1'b1 || cDone !== 1'b0 || dRdata !== c_DATA_B) begin
                    nErr++; $display("FAIL tie%0d_ddone: got d=%b c=%b data=%h, want 1 0 %h", i, dDone, cDone, dRdata, c_DATA_B);
                end
            end
            tick();
        end
        cReq = 0; dReq = 0;
        tick();
    endtask

    task automatic test_d_rd_c_write();
        dReq = 1; dWe = 0; dAddr = 32'h20;
        @(negedge clk);
        nVec++;
        if (memRe !== 1'b1 || memAddr !== 32'h20 || dDone !== 1'b0) begin
            nErr++; $display("FAIL drd_issue: got re=%b addr=%h done=%b, want 1 00000020 0", memRe, memAddr, dDone);
        end
        tick();
        cReq = 1; cWe = 1; cAddr = 32'h30; cWdata = 32'h12345678;
        @(negedge clk);
        nVec++;
        if (dDone !== 1'b1 || dRdata !== c_DATA_A || cStall !== 1'b1 || memWe !== 1'b0 || memAddr !== 32'h20) begin
            nErr++; $display("FAIL drd_cblocked: got d=%b data=%h stall=%b we=%b addr=%h, want 1 %h 1 0 00000020",
                             dDone, dRdata, cStall, memWe, memAddr, c_DATA_A);
        end
        tick();
        dReq = 0;
        @(negedge clk);
        nVec++;
        if (memWe !== 1'b1 || memAddr !== 32'h30 || memWdata !== 32'h12345678 || cDone !== 1'b1 || cStall !== 1'b0) begin
            nErr++; $display("FAIL cwr_after_drd: got we=%b addr=%h wd=%h done=%b stall=%b, want 1 00000030 12345678 1 0",
                             memWe, memAddr, memWdata, cDone, cStall);
        end
        tick();
        cWe = 0;
        @(negedge clk);
        nVec++;
        if (memRe !== 1'b1 || cDone !== 1'b0) begin
            nErr++; $display("FAIL crd_back_issue: got re=%b done=%b, want 1 0", memRe, cDone);
        end
        tick();
        @(negedge clk);
        nVec++;
        if (cDone !== 1'b1 || cRdata !== 32'h12345678) begin
            nErr++; $display("FAIL crd_back_data: got done=%b data=%h, want 1 12345678", cDone, cRdata);
        end
        tick();
        cReq = 0;
        tick();
    endtask

    task automatic test_reset_mid_read();
        cReq = 1; cWe = 0; cAddr = 32'h24;
        @(negedge clk);
        nVec++;
        if (memRe !== 1'b1) begin
            nErr++; $display("FAIL rmid_issue: got re=%b, want 1", memRe);
        end
        tick();
        reset = 1;
        @(negedge clk);
        nVec++;
        if (cDone !== 1'b0) begin
            nErr++; $display("FAIL rmid_nodone: got %b, want 0", cDone);
        end
        tick();
        cReq = 0;
        reset = 0;
        @(negedge clk);
        nVec++;
        if (cDone !== 1'b0 || memRe !== 1'b0 || stallCnt !== 16'd0 || cRdata !== 32'd0) begin
            nErr++; $display("FAIL rmid_idle: got done=%b re=%b cnt=%0d data=%h, want 0 0 0 00000000",
                             cDone, memRe, stallCnt, cRdata);
        end
        tick();
        cReq = 1; cWe = 1; cAddr = 32'h34; cWdata = 32'h0BADF00D;
        @(negedge clk);
        nVec++;
        if (cDone !== 1'b1 || memWe !== 1'b1) begin
            nErr++; $display("FAIL rmid_newwr: got done=%b we=%b, want 1 1", cDone, memWe);
        end
        tick();
        cReq = 0;
        tick();
    endtask

    task automatic test_saturation();
        reset = 1;
        tick();
        reset = 0;
        cReq = 1; cWe = 0; cAddr = 32'h20;
        dReq = 1; dWe = 0; dAddr = 32'h24;
        // Alternating C/D reads: 3 stall cycles out of every 4.
        repeat (16) tick();
        @(negedge clk);
        nVec++;
        if (stallCnt !== 16'd12 || stallCnt4 !== 4'd12) begin
            nErr++; $display("FAIL sat_16: got %0d/%0d, want 12/12", stallCnt, stallCnt4);
        end
        repeat (4) tick();
        @(negedge clk);
        nVec++;
        if (stallCnt !== 16'd15 || stallCnt4 !== 4'd15) begin
            nErr++; $display("FAIL sat_20: got %0d/%0d, want 15/15", stallCnt, stallCnt4);
        end
        repeat (4) tick();
        @(negedge clk);
        nVec++;
        if (stallCnt !== 16'd18 || stallCnt4 !== 4'd15) begin
            nErr++; $display("FAIL sat_24: got %0d/%0d, want 18/15", stallCnt, stallCnt4);
        end
        repeat (16) tick();
        @(negedge clk);
        nVec++;
        if (stallCnt !== 16'd30 || stallCnt4 !== 4'd15) begin
            nErr++; $display("FAIL sat_40: got %0d/%0d, want 30/15", stallCnt, stallCnt4);
        end
        tick();
        cReq = 0; dReq = 0;
        tick();
    endtask

    initial begin
        reset = 1;
        clearInputs();
        test_reset();
        test_write_read();
        test_tie();
        test_d_rd_c_write();
        test_reset_mid_read();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end

endmodule
`default_nettype wire
